sram_port_arbiter: RTL and testbench

Shares one 2-read/1-write synchronous block SRAM among NUM_REQUESTERS clients. Each cycle it grants up to two reads and one write, using independent round-robin pointers for reads and writes. It drives the SRAM ports directly and routes each read result back to its requester one cycle after the grant. It sits between the texture/tile fetch clients and the shared on-chip buffer.

---
 rtl/sram_arb_pkg.sv | 17 +
 rtl/sram_port_arbiter_rr_picker.sv | 30 +++
 rtl/sram_port_arbiter.sv | 130 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM port arbiter.
// Index type is sized for the largest supported client count (8).
package sram_arb_pkg;

  localparam int MAX_REQUESTERS = 8;
  localparam int REQ_IDX_W      = $clog2(MAX_REQUESTERS);
  localparam int PERF_CNT_W     = 32;

  typedef logic [REQ_IDX_W-1:0] requester_idx_t;

  typedef enum logic {RD_PORT1 = 1'b0, RD_PORT2 = 1'b1} rd_port_t;

  function automatic requester_idx_t next_ptr(input requester_idx_t idx, input int n);
    return requester_idx_t'((int'(idx) + 1) % n);
  endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of req scanning upward
// from ptr with wrap-around. Outputs one-hot grant plus its index.
module rr_picker
  import sram_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]   req,
  input  requester_idx_t ptr,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output requester_idx_t gnt_idx
);

  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!gnt_valid && req[i] && (i == (int'(ptr) + k) % N)) begin
          gnt_valid = 1'b1;
          gnt[i]    = 1'b1;
          gnt_idx   = requester_idx_t'(i);
        end
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares a 2R/1W synchronous SRAM among NUM_REQUESTERS clients with RR grants.
// Optional stall counters are built when SRAM_ARB_PERF_EN is defined.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int SIZE           = 1024,
  parameter int ADDR_WIDTH     = $clog2(SIZE)
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic [NUM_REQUESTERS-1:0]                req_valid,
  output logic [NUM_REQUESTERS-1:0]                req_ready,
  input  logic [NUM_REQUESTERS-1:0]                req_write,
  input  logic [NUM_REQUESTERS-1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQUESTERS-1:0]                resp_valid,
  output logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0] resp_rdata,
  output logic                                     sram_read1_en,
  output logic [ADDR_WIDTH-1:0]                    sram_read1_addr,
  input  logic [DATA_WIDTH-1:0]                    sram_read1_data,
  output logic                                     sram_read2_en,
  output logic [ADDR_WIDTH-1:0]                    sram_read2_addr,
  input  logic [DATA_WIDTH-1:0]                    sram_read2_data,
  output logic                                     sram_write_en,
  output logic [ADDR_WIDTH-1:0]                    sram_write_addr,
  output logic [DATA_WIDTH-1:0]                    sram_write_data
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0]                    perf_read_stall,
  output logic [PERF_CNT_W-1:0]                    perf_write_stall
`endif
);

  logic [NUM_REQUESTERS-1:0] rd_req, wr_req, rd_gnt1, rd_gnt2, wr_gnt, rd_gnt;
  logic [NUM_REQUESTERS-1:0] resp_vld_q;
  logic                      rd_v1, rd_v2, wr_v;
  requester_idx_t            rd_ptr, wr_ptr, rd_idx1, rd_idx2, wr_idx;

  assign rd_req = req_valid & ~req_write;
  assign wr_req = req_valid &  req_write;

  rr_picker #(.N(NUM_REQUESTERS)) u_rd1 (
    .req(rd_req), .ptr(rd_ptr), .gnt(rd_gnt1), .gnt_valid(rd_v1), .gnt_idx(rd_idx1)
  );

  // Second read port scans the same order with the first winner masked out.
  rr_picker #(.N(NUM_REQUESTERS)) u_rd2 (
    .req(rd_req & ~rd_gnt1), .ptr(rd_ptr), .gnt(rd_gnt2), .gnt_valid(rd_v2), .gnt_idx(rd_idx2)
  );

  rr_picker #(.N(NUM_REQUESTERS)) u_wr (
    .req(wr_req), .ptr(wr_ptr), .gnt(wr_gnt), .gnt_valid(wr_v), .gnt_idx(wr_idx)
  );

  assign rd_gnt        = reset_n ? (rd_gnt1 | rd_gnt2) : '0;
  assign req_ready     = reset_n ? (rd_gnt1 | rd_gnt2 | wr_gnt) : '0;
  assign sram_read1_en = reset_n & rd_v1;
  assign sram_read2_en = reset_n & rd_v2;
  assign sram_write_en = reset_n & wr_v;
  assign resp_valid    = resp_vld_q;

  always_comb begin
    sram_read1_addr = '0;
    sram_read2_addr = '0;
    sram_write_addr = '0;
    sram_write_data = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (rd_gnt1[i]) sram_read1_addr = req_addr[i];
      if (rd_gnt2[i]) sram_read2_addr = req_addr[i];
      if (wr_gnt[i]) begin
        sram_write_addr = req_addr[i];
        sram_write_data = req_wdata[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      resp_vld_q <= '0;
    end else begin
      if (rd_v2)      rd_ptr <= next_ptr(rd_idx2, NUM_REQUESTERS);
      else if (rd_v1) rd_ptr <= next_ptr(rd_idx1, NUM_REQUESTERS);
      if (wr_v)       wr_ptr <= next_ptr(wr_idx, NUM_REQUESTERS);
      resp_vld_q <= rd_gnt;
    end
  end

  // Per-lane return path: the port tag steers SRAM data, idle lanes hold.
  for (genvar i = 0; i < NUM_REQUESTERS; i++) begin : g_lane
    rd_port_t              tag_q;
    logic [DATA_WIDTH-1:0] hold_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        tag_q  <= RD_PORT1;
        hold_q <= '0;
      end else begin
        if (rd_gnt[i])     tag_q  <= rd_gnt2[i] ? RD_PORT2 : RD_PORT1;
        if (resp_vld_q[i]) hold_q <= resp_rdata[i];
      end
    end

    assign resp_rdata[i] = !resp_vld_q[i]     ? hold_q :
                           (tag_q == RD_PORT2) ? sram_read2_data : sram_read1_data;
  end

`ifdef SRAM_ARB_PERF_EN
  logic rd_stall, wr_stall;

  assign rd_stall = |(rd_req & ~(rd_gnt1 | rd_gnt2));
  assign wr_stall = |(wr_req & ~wr_gnt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_read_stall  <= '0;
      perf_write_stall <= '0;
    end else begin
      if (rd_stall && (perf_read_stall != '1))
        perf_read_stall <= perf_read_stall + PERF_CNT_W'(1);
      if (wr_stall && (perf_write_stall != '1))
        perf_write_stall <= perf_write_stall + PERF_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a NEW_DATA 2R/1W SRAM model
// and a read-response scoreboard. Perf checks build with SRAM_ARB_PERF_EN.
module tb_sram_port_arbiter;
  localparam int N = 4, DW = 32, SIZE = 1024, AW = 10;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [N-1:0]         req_valid, req_ready, req_write, resp_valid;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][DW-1:0] req_wdata, resp_rdata;
  logic                 sram_read1_en, sram_read2_en, sram_write_en;
  logic [AW-1:0]        sram_read1_addr, sram_read2_addr, sram_write_addr;
  logic [DW-1:0]        sram_read1_data, sram_read2_data, sram_write_data;
`ifdef SRAM_ARB_PERF_EN
  logic [31:0]          perf_read_stall, perf_write_stall;
`endif

  sram_port_arbiter #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW), .SIZE(SIZE)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .sram_read1_en(sram_read1_en), .sram_read1_addr(sram_read1_addr), .sram_read1_data(sram_read1_data),
    .sram_read2_en(sram_read2_en), .sram_read2_addr(sram_read2_addr), .sram_read2_data(sram_read2_data),
    .sram_write_en(sram_write_en), .sram_write_addr(sram_write_addr), .sram_write_data(sram_write_data)
`ifdef SRAM_ARB_PERF_EN
    , .perf_read_stall(perf_read_stall), .perf_write_stall(perf_write_stall)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [SIZE];

  function automatic logic [DW-1:0] init_val(input int a);
    return 32'hA500_0000 + 32'(a);
  endfunction

  // NEW_DATA SRAM: a read colliding with a same-cycle write sees the new word.
  always @(posedge clk) begin
    if (sram_write_en) mem[sram_write_addr] <= sram_write_data;
    if (sram_read1_en)
      sram_read1_data <= (sram_write_en && sram_write_addr == sram_read1_addr) ? sram_write_data : mem[sram_read1_addr];
    if (sram_read2_en)
      sram_read2_data <= (sram_write_en && sram_write_addr == sram_read2_addr) ? sram_write_data : mem[sram_read2_addr];
  end

  typedef struct {
    logic [1:0]    client;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0, cyc = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_resps();
    logic [N-1:0] exp_v;
    exp_v = '0;
    foreach (sb[k]) if (sb[k].due == cyc) exp_v[sb[k].client] = 1'b1;
    chk("resp_valid", 32'(resp_valid), 32'(exp_v));
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].due == cyc) begin
        chk($sformatf("resp_rdata[%0d]", sb[k].client), resp_rdata[sb[k].client], sb[k].data);
        sb.delete(k);
      end
    end
  endtask

  task automatic exp_rd(input logic [1:0] c, input logic [DW-1:0] d);
    sb.push_back('{client: c, data: d, due: cyc + 1});
  endtask

  task automatic at_neg();
    @(negedge clk);
    check_resps();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic set_rd(input logic [1:0] i, input logic [AW-1:0] a);
    req_valid[i] = 1'b1; req_write[i] = 1'b0; req_addr[i] = a;
  endtask

  task automatic set_wr(input logic [1:0] i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1; req_write[i] = 1'b1; req_addr[i] = a; req_wdata[i] = d;
  endtask

  task automatic do_reset();
    idle();
    at_neg();
    adv();
    reset_n = 1'b0;
    at_neg();
    chk("rst_ready", 32'(req_ready), 32'h0);
    adv();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [3:0] rmask;
    int lo;
    for (int a = 0; a < SIZE; a++) mem[a] <= init_val(a);
    idle();
    reset_n = 1'b0;
    for (int i = 0; i < N; i++) set_rd(2'(i), AW'(16 + i));

    // In reset with all clients requesting: nothing may reach the SRAM.
    at_neg();
    chk("reset_ready", 32'(req_ready), 32'h0);
    chk("reset_rd1_en", 32'(sram_read1_en), 32'h0);
    chk("reset_rd2_en", 32'(sram_read2_en), 32'h0);
    chk("reset_wr_en", 32'(sram_write_en), 32'h0);
`ifdef SRAM_ARB_PERF_EN
    chk("reset_perf_rd", perf_read_stall, 32'h0);
`endif
    adv();
    reset_n = 1'b1;

    // Four continuous readers: pairs alternate {0,1},{2,3}.
    for (int c = 0; c < 5; c++) begin
      at_neg();
      lo = (c % 2 == 0) ? 0 : 2;
      chk("rd_ready", 32'(req_ready), (c % 2 == 0) ? 32'h3 : 32'hC);
      chk("rd1_en", 32'(sram_read1_en), 32'h1);
      chk("rd2_en", 32'(sram_read2_en), 32'h1);
      chk("rd1_addr", 32'(sram_read1_addr), 32'(16 + lo));
      chk("rd2_addr", 32'(sram_read2_addr), 32'(17 + lo));
      if (c < 4) begin
        exp_rd(2'(lo), init_val(16 + lo));
        exp_rd(2'(lo + 1), init_val(17 + lo));
        adv();
      end
    end

    // Reset asserted right after a grant: that grant must never respond.
    #1 reset_n = 1'b0;
    adv();
    at_neg();
    chk("midrst_ready", 32'(req_ready), 32'h0);
    chk("midrst_rd1_en", 32'(sram_read1_en), 32'h0);
    chk("midrst_rd2_en", 32'(sram_read2_en), 32'h0);
    chk("midrst_wr_en", 32'(sram_write_en), 32'h0);
    adv();
    reset_n = 1'b1;
    at_neg();
    chk("postrst_ready", 32'(req_ready), 32'h3);
    exp_rd(2'd0, init_val(16));
    exp_rd(2'd1, init_val(17));
    adv();

    // Four continuous writers: single grant rotating 0,1,2,3,0.
    idle();
    for (int i = 0; i < N; i++) set_wr(2'(i), AW'(256 + i), 32'hC0DE_0000 + 32'(i));
    for (int c = 0; c < 5; c++) begin
      at_neg();
      chk("wr_ready", 32'(req_ready), 32'(1) << (c % 4));
      chk("wr_en", 32'(sram_write_en), 32'h1);
      chk("wr_addr", 32'(sram_write_addr), 32'(256 + c % 4));
      chk("wr_data", sram_write_data, 32'hC0DE_0000 + 32'(c % 4));
      chk("wr_rd1_en", 32'(sram_read1_en), 32'h0);
      adv();
    end

    // Same-cycle write and read of 0x20 by different clients.
    idle();
    set_wr(2'd1, AW'(32), 32'hDEAD_BEEF);
    set_rd(2'd2, AW'(32));
    at_neg();
    chk("raw_ready", 32'(req_ready), 32'h6);
    chk("raw_wr_addr", 32'(sram_write_addr), 32'h20);
    chk("raw_rd1_addr", 32'(sram_read1_addr), 32'h20);
    chk("raw_rd2_en", 32'(sram_read2_en), 32'h0);
    chk("raw_rd2_addr", 32'(sram_read2_addr), 32'h0);
    exp_rd(2'd2, 32'hDEAD_BEEF);
    adv();
    do_reset();

    // Mixed: 0 and 3 read on both ports, writers 1 then 2.
    set_rd(2'd0, AW'(48));
    set_rd(2'd3, AW'(51));
    set_wr(2'd1, AW'(64), 32'h1111_1111);
    set_wr(2'd2, AW'(65), 32'h2222_2222);
    for (int c = 0; c < 2; c++) begin
      at_neg();
      chk("mix_ready", 32'(req_ready), (c == 0) ? 32'hB : 32'hD);
      chk("mix_rd1_addr", 32'(sram_read1_addr), 32'h30);
      chk("mix_rd2_addr", 32'(sram_read2_addr), 32'h33);
      chk("mix_wr_addr", 32'(sram_write_addr), (c == 0) ? 32'h40 : 32'h41);
      chk("mix_wr_data", sram_write_data, (c == 0) ? 32'h1111_1111 : 32'h2222_2222);
      exp_rd(2'd0, init_val(48));
      exp_rd(2'd3, init_val(51));
      adv();
    end
    do_reset();

    // Three readers for 10 cycles: one is always left waiting.
    for (int i = 0; i < 3; i++) set_rd(2'(i), AW'(80 + i));
    for (int c = 0; c < 10; c++) begin
      at_neg();
      rmask = (c % 3 == 0) ? 4'b0011 : (c % 3 == 1) ? 4'b0101 : 4'b0110;
      chk("stall_ready", 32'(req_ready), 32'(rmask));
      for (int i = 0; i < 3; i++) if (rmask[i]) exp_rd(2'(i), init_val(80 + i));
      adv();
    end
    idle();
    at_neg();
`ifdef SRAM_ARB_PERF_EN
    chk("perf_read_stall", perf_read_stall, 32'd10);
    chk("perf_write_stall", perf_write_stall, 32'd0);
`endif
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
